// File: rtl/tpu_host_driver.sv
// Initiator-side driver for the TPU operand/result interface: one operation in flight,
// sync pulse, two-half result readback and a WAIT watchdog. Optional TPU_HOST_STATS_EN adds result counters.
`timescale 1ns/1ps

module tpu_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        sync,
  output logic        out_HL,
  output logic [7:0]  input1,
  output logic [7:0]  input2,
  input  logic        tpu_ready,
  input  logic        tpu_error,
  input  logic [15:0] tpu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_code
`ifdef TPU_HOST_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_err,
  output logic [15:0] stat_to
`endif
);

  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_ERR = 2'b01;
  localparam logic [1:0] CODE_TO  = 2'b10;
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RD_LO, RD_HI0, RD_HI1, DONE
  } state_t;

  state_t          state;
  logic [TO_W-1:0] wd;

  // Gated with reset so the port reads 0 during the reset cycle and 1 right after it.
  assign cmd_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wd        <= '0;
      sync      <= 1'b0;
      out_HL    <= 1'b0;
      input1    <= '0;
      input2    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_code  <= CODE_OK;
    end else begin
      sync <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            input1 <= cmd_a;
            input2 <= cmd_b;
            sync   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wd     <= '0;
          out_HL <= 1'b0;
          state  <= WAIT;
        end
        // Error wins over a simultaneous ready; timeout only when neither shows up.
        WAIT: begin
          if (tpu_error) begin
            res_code  <= CODE_ERR;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (tpu_ready) begin
            state <= RD_LO;
          end else if (wd == WD_LAST) begin
            res_code  <= CODE_TO;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        RD_LO: begin
          res_data[15:0] <= tpu_out;
          out_HL         <= 1'b1;
          state          <= RD_HI0;
        end
        RD_HI0: begin
          state <= RD_HI1;
        end
        RD_HI1: begin
          res_data[31:16] <= tpu_out;
          res_code        <= CODE_OK;
          out_HL          <= 1'b0;
          res_valid       <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TPU_HOST_STATS_EN
  logic done_hs;
  assign done_hs = (state == DONE) && res_valid && res_ready;

  // Saturating per-outcome counters, bumped on the result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops <= '0;
      stat_err <= '0;
      stat_to  <= '0;
    end else if (done_hs) begin
      if (res_code == CODE_OK  && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (res_code == CODE_ERR && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      if (res_code == CODE_TO  && stat_to  != 16'hFFFF) stat_to  <= stat_to  + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver: vector table of operations plus reset corner sequences.
`timescale 1ns/1ps

module tb_tpu_host_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic        sync, out_HL;
  logic [7:0]  input1, input2;
  logic        tpu_ready, tpu_error;
  logic [15:0] tpu_out;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_code;
`ifdef TPU_HOST_STATS_EN
  logic [15:0] stat_ops, stat_err, stat_to;
`endif

  logic [31:0] cur_res;
  int tests = 0;
  int fails = 0;
  int exp_ops = 0, exp_err = 0, exp_to = 0;

  always #5 clk = ~clk;

  // TPU model: result half follows out_HL combinationally.
  assign tpu_out = out_HL ? cur_res[31:16] : cur_res[15:0];

  tpu_host_driver #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .sync(sync), .out_HL(out_HL), .input1(input1), .input2(input2),
    .tpu_ready(tpu_ready), .tpu_error(tpu_error), .tpu_out(tpu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_code(res_code)
`ifdef TPU_HOST_STATS_EN
    , .stat_ops(stat_ops), .stat_err(stat_err), .stat_to(stat_to)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] result;
    int          delay;    // cycles after sync that ready appears; -1 = never
    bit          err;      // assert tpu_error together with tpu_ready
    int          hold;     // cycles res_ready stays low in DONE
    logic [31:0] exp_data;
    logic [1:0]  exp_code;
    int          exp_lat;  // cycle of res_valid, sync cycle = 1
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int c, lat, sync_hi, hl_err, in_err, hold_err;
    bit seen;
    logic exp_hl;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cur_res = v.result;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = ~v.a; cmd_b = ~v.b;
    c = 1; lat = 0; seen = 1'b0; sync_hi = 0; hl_err = 0; in_err = 0;
    while (!seen && c <= 40) begin
      if (sync) sync_hi++;
      if (input1 !== v.a || input2 !== v.b) in_err++;
      exp_hl = (v.exp_code == 2'b00) && (c == v.delay + 3 || c == v.delay + 4);
      if (out_HL !== exp_hl) hl_err++;
      if (res_valid) begin
        seen = 1'b1; lat = c;
      end else begin
        tpu_ready = (v.delay >= 0) && (c == 1 + v.delay);
        tpu_error = v.err && tpu_ready;
        @(negedge clk);
        c++;
      end
    end
    tpu_ready = 1'b0; tpu_error = 1'b0;
    chk("res_valid_seen", 32'(seen), 32'd1);
    chk("sync_pulse_cycles", 32'(sync_hi), 32'd1);
    chk("operands_stable", 32'(in_err), 32'd0);
    chk("out_hl_sequence", 32'(hl_err), 32'd0);
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("res_data", res_data, v.exp_data);
    chk("res_code", 32'(res_code), 32'(v.exp_code));
    hold_err = 0;
    for (int h = 0; h <= v.hold; h++) begin
      if (h > 0) @(negedge clk);
      if (!res_valid || res_data !== v.exp_data || res_code !== v.exp_code || cmd_ready !== 1'b0)
        hold_err++;
    end
    chk("done_hold_stable", 32'(hold_err), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    case (v.exp_code)
      2'b00:   exp_ops++;
      2'b01:   exp_err++;
      default: exp_to++;
    endcase
  endtask

  vec_t vecs[6];

  initial begin
    vec_t fresh;
    vecs[0] = '{8'h0D, 8'h0F, 32'h0000_00C3,  3, 1'b0, 0, 32'h0000_00C3, 2'b00,  8};
    vecs[1] = '{8'h12, 8'h34, 32'hBEEF_1234,  1, 1'b0, 5, 32'hBEEF_1234, 2'b00,  6};
    vecs[2] = '{8'hAA, 8'h55, 32'hDEAD_BEEF,  2, 1'b1, 1, 32'h0000_0000, 2'b01,  4};
    vecs[3] = '{8'h01, 8'h02, 32'h0001_0002,  1, 1'b0, 0, 32'h0001_0002, 2'b00,  6};
    vecs[4] = '{8'h77, 8'h88, 32'h1111_2222, -1, 1'b0, 2, 32'h0000_0000, 2'b10, 10};
    vecs[5] = '{8'hFF, 8'h00, 32'hFFFF_0000,  5, 1'b0, 0, 32'hFFFF_0000, 2'b00, 10};
    fresh   = '{8'h5A, 8'hA5, 32'h1234_5678,  2, 1'b0, 1, 32'h1234_5678, 2'b00,  7};

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
    tpu_ready = 1'b0; tpu_error = 1'b0; res_ready = 1'b0; cur_res = '0;

    // Reset for two cycles, then check idle values right after release.
    @(negedge clk);
    @(negedge clk);
    chk("cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_out_hl", 32'(out_HL), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_code", 32'(res_code), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_input1", 32'(input1), 32'd0);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Reset while in RD_HI0: abort with no partial result kept.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 8'h21; cmd_b = 8'h43; cur_res = 32'hCAFE_F00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    tpu_ready = 1'b1;
    @(negedge clk);
    tpu_ready = 1'b0;
    @(negedge clk);
    chk("rdhi0_out_hl", 32'(out_HL), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_hl", 32'(out_HL), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_data", res_data, 32'd0);
    chk("midrst_input1", 32'(input1), 32'd0);
    reset = 1'b0;
    exp_ops = 0; exp_err = 0; exp_to = 0;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);

    run_op(fresh);

`ifdef TPU_HOST_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'(exp_ops));
    chk("stat_err", 32'(stat_err), 32'(exp_err));
    chk("stat_to", 32'(stat_to), 32'(exp_to));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
Name: tpu_host_driver

Overview:
- Initiator-side driver for the TPU operand/result interface; sits between an upstream command stream and the TPU core.
- Accepts one operand pair per command, issues a one-cycle sync to the TPU and waits for ready/error.
- Reads the 32-bit result as two 16-bit halves selected by out_HL (0 = low half, 1 = high half) and presents it downstream with a status code.
- One operation in flight at a time; a watchdog guards against a TPU that never responds.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before aborting with a timeout; legal range 1..65535.
- TO_W, 16: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  sole clock, rising-edge.
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where reset=1.
- cmd_valid  input  1  upstream has an operand pair.
- cmd_ready  output  1  driver can accept a command (high only in IDLE).
- cmd_a  input  8  operand for TPU input1.
- cmd_b  input  8  operand for TPU input2.
- sync  output  1  start pulse to TPU.
- out_HL  output  1  result half select to TPU.
- input1  output  8  operand A to TPU.
- input2  output  8  operand B to TPU.
- tpu_ready  input  1  TPU result available.
- tpu_error  input  1  TPU error flag.
- tpu_out  input  16  TPU result half.
- res_valid  output  1  result available downstream.
- res_ready  input  1  downstream accepts result.
- res_data  output  32  assembled result {high, low}.
- res_code  output  2  00 ok, 01 TPU error, 10 timeout.

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle, then 1 in IDLE; sync=0, out_HL=0, input1=0, input2=0, res_valid=0, res_data=0, res_code=00; FSM=IDLE; watchdog=0.
- Reset asserted mid-operation: abort immediately to IDLE with the reset values above. No result is emitted and no partial half is retained.
- FSM states: IDLE, ISSUE, WAIT, RD_LO, RD_HI0, RD_HI1, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_a→input1, cmd_b→input2, go to ISSUE.
- ISSUE
  - sync=1 for exactly this one cycle; clear the watchdog; go to WAIT.
- WAIT
  - sync=0, out_HL=0; watchdog increments each cycle.
  - tpu_error=1: res_code=01, res_data=0, go to DONE. Error has priority over a simultaneous tpu_ready.
  - Otherwise tpu_ready=1: go to RD_LO.
  - Otherwise, when watchdog reaches TIMEOUT_CYCLES-1: res_code=10, res_data=0, go to DONE.
- RD_LO
  - out_HL=0; capture tpu_out→res_data[15:0] at the end of the cycle; go to RD_HI0.
- RD_HI0
  - out_HL=1; settle cycle, no capture.
- RD_HI1
  - out_HL=1; capture tpu_out→res_data[31:16]; res_code=00; go to DONE.
- DONE
  - out_HL=0, res_valid=1.
  - res_data and res_code are held stable until res_valid&&res_ready; then res_valid=0 and go to IDLE.
- input1/input2 hold their latched values from ISSUE until a new command is accepted. They never change while sync=1 or the FSM is in WAIT.
- Latency: command accepted at edge 0 → sync high in cycle 1 → tpu_ready seen in cycle N → res_valid in cycle N+4. Minimum 6 cycles from accept to res_valid.
- Throughput: one op at a time. cmd_ready is deasserted from ISSUE until the cycle after the DONE handshake.
- tpu_ready or tpu_error outside WAIT is ignored.

Optional Feature:
- Macro: TPU_HOST_STATS_EN.
- Defined:
  - Adds outputs stat_ops[15:0] (completed ok results), stat_err[15:0] (res_code 01) and stat_to[15:0] (res_code 10).
  - Each counter increments on the DONE handshake cycle, saturates at 0xFFFF and clears on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset for 2 cycles then release; sample immediately → sync=0, out_HL=0, res_valid=0, res_code=00, cmd_ready=1 on the first cycle after reset.
- cmd_a=0x0D, cmd_b=0x0F against a TPU model returning 0x000000C3 with ready 3 cycles after sync → sync high exactly 1 cycle, input1=0x0D, input2=0x0F, out_HL sequence 0,1,1, res_data=0x000000C3, res_code=00, res_valid 4 cycles after tpu_ready.
- TPU model result 0xBEEF1234 with res_ready held low 5 cycles → res_data={0xBEEF,0x1234} stable and res_valid=1 throughout; cmd_ready=0 until the cycle after the handshake.
- tpu_error and tpu_ready asserted together in WAIT → res_code=01, res_data=0; the next command completes normally.
- TPU never responds, TIMEOUT_CYCLES=8 → res_valid rises with res_code=10 after 8 WAIT cycles; with TPU_HOST_STATS_EN defined, stat_to=1 after the handshake.
- Reset asserted during RD_HI0 → next cycle FSM is IDLE, out_HL=0, res_valid=0; a fresh command then yields a correct result.
